mmu_data_demux: RTL and testbench
=================================

# mmu_data_demux

Routes the single shared DMA read-data stream back to the per-region user streams. Consumes the multiplexing sequence produced by the MMU arbiter, one entry per granted DMA request: `{last, vfid, len}`. Steers exactly `len+1` data beats of each entry to region `vfid`, regenerating per-region `tlast`. Sits between the DMA engine's read-data AXI stream and the `N_REGIONS` user-side data streams.

## Interface
Parameters:
- `N_REGIONS`, default 4: number of user regions; must be ≥ 1.
- `N_REGIONS_BITS`, default `clog2(N_REGIONS)` (min 1): vfid width.
- `DATA_BITS`, default 512: data bus width.
- `BLEN_BITS`, default `LEN_BITS - clog2(DATA_BITS/8)`: beat-count width.

Ports (one clock; reset is asynchronous and active-low):
- `aclk`  in  1  clock.
- `aresetn`  in  1  asynchronous active-low reset.
- `s_mux_valid`  in  1  sequence entry valid.
- `s_mux_ready`  out  1  sequence entry accept.
- `s_mux_vfid`  in  N_REGIONS_BITS  destination region.
- `s_mux_len`  in  BLEN_BITS  beats minus one.
- `s_mux_last`  in  1  entry closes a user transfer; gates output `tlast`.
- `s_axis_tvalid` / `s_axis_tready`  in/out  1  DMA read-data handshake.
- `s_axis_tdata`  in  DATA_BITS; `s_axis_tkeep`  in  DATA_BITS/8; `s_axis_tlast`  in  1.
- `m_axis_tvalid[N_REGIONS]` / `m_axis_tready[N_REGIONS]`  out/in  1 each.
- `m_axis_tdata[N_REGIONS]`  out  DATA_BITS; `m_axis_tkeep[N_REGIONS]`  out  DATA_BITS/8; `m_axis_tlast[N_REGIONS]`  out  1.
- `err`  out  1  sticky framing error (see Configuration).

## Operation
- State: `IDLE`, `XFER`. Registers: `vfid_r`, `len_r`, `last_r`, beat counter `cnt` (BLEN_BITS).
- IDLE:
  - `s_mux_ready=1`, `s_axis_tready=0`, all `m_axis_tvalid=0`.
  - On `s_mux` handshake: latch vfid/len/last, `cnt<=0`, go to XFER.
- XFER: combinational pass-through to region `vfid_r`.
  - `m_axis_tvalid[vfid_r]=s_axis_tvalid`; all other regions' tvalid = 0.
  - `s_axis_tready=m_axis_tready[vfid_r]`.
  - tdata and tkeep driven to the selected port; non-selected ports' data is don't-care, driven 0.
  - `m_axis_tlast[vfid_r] = final & last_r`, where `final = (cnt==len_r)`. Input `s_axis_tlast` is ignored for routing.
  - Each beat handshake: `cnt<=cnt+1`.
  - On the final-beat handshake with `s_mux_valid=1`: `s_mux_ready=1` in the same cycle; load the new entry and `cnt<=0`; stay in XFER (back-to-back, no bubble).
  - On the final-beat handshake with `s_mux_valid=0`: go to IDLE.
  - `s_mux_ready=0` in XFER except on the final-beat handshake.
- `len=0` denotes a single beat; `len` = all ones denotes 2^BLEN_BITS beats. `cnt` never wraps within an entry.
- `vfid ≥ N_REGIONS`: entry is consumed and its beats are handshaken and dropped (`s_axis_tready=1`, no output valid). Sets `err` when checking is enabled.
- Reset mid-transfer: state returns to IDLE and the entry is lost. Upstream resets together.

## Timing
- Reset values: state IDLE, cnt 0, `err` 0, all outputs 0.
  - `s_mux_ready` is 0 while `aresetn=0` and 1 from the first cycle after release.
- Sequence-to-first-beat latency: 1 cycle. The beat can pass in the cycle after the entry handshake.
- Data path latency: 0 cycles (combinational); no data buffering.
- Sustained throughput: 1 beat/cycle across entry boundaries; no bubble between consecutive entries.
- No ready-to-valid dependency on any outputs except the documented `s_axis_tready` ← `m_axis_tready[vfid_r]` path.
- `m_axis_tvalid` may deassert only when `s_axis_tvalid` deasserts; upstream must hold AXI-stream stability.

## Configuration
- `MMU_DMUX_ERR_CHECK_EN` defined:
  - `err` is set, and held until reset, when `s_axis_tlast=1` on a non-final beat.
  - It is also set when `s_axis_tlast=0` on a final beat of an entry with `last_r=1`, or on an out-of-range vfid.
  - Routing is unaffected; the counter remains authoritative.
- Not defined: `err` is tied to 0 and the check logic is not instantiated.

## Test plan
- Single entry vfid=2, len=3, last=1; 4 beats D0..D3 → region 2 receives D0..D3; tlast only on D3; other regions see no valid.
- Entries (0,len=1,last=0) then (1,len=0,last=1) presented back-to-back → 3 consecutive cycles of beats, no bubble; region 0 tlast=0, region 1 tlast=1 on its single beat.
- Region 1 tready low for 5 cycles mid-entry → `s_axis_tready` low for those cycles; cnt holds; no beat lost or duplicated.
- len = 2^BLEN_BITS−1 entry → exactly 2^BLEN_BITS beats forwarded; transition to IDLE after the last one.
- Reset asserted during beat 2 of a len=7 entry → all outputs 0 immediately; after release, a new entry vfid=0 len=0 routes correctly.
- With `MMU_DMUX_ERR_CHECK_EN`: `s_axis_tlast=1` on beat 1 of a len=3 entry → `err`=1 on the next cycle and it stays 1; all 4 beats are still routed.

Source files
------------

// File: rtl/mmu_data_demux.sv
// Steers the shared DMA read-data stream to per-region user streams, one sequence entry at a time.
// Optional framing checker enabled by defining MMU_DMUX_ERR_CHECK_EN.
module mmu_data_demux #(
  parameter int unsigned N_REGIONS      = 4,
  parameter int unsigned N_REGIONS_BITS = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1,
  parameter int unsigned DATA_BITS      = 512,
  parameter int unsigned LEN_BITS       = 28,
  parameter int unsigned BLEN_BITS      = LEN_BITS - $clog2(DATA_BITS / 8)
) (
  input  logic                              aclk,
  input  logic                              aresetn,

  input  logic                              s_mux_valid,
  output logic                              s_mux_ready,
  input  logic [N_REGIONS_BITS-1:0]         s_mux_vfid,
  input  logic [BLEN_BITS-1:0]              s_mux_len,
  input  logic                              s_mux_last,

  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [DATA_BITS-1:0]              s_axis_tdata,
  input  logic [DATA_BITS/8-1:0]            s_axis_tkeep,
  input  logic                              s_axis_tlast,

  output logic [N_REGIONS-1:0]              m_axis_tvalid,
  input  logic [N_REGIONS-1:0]              m_axis_tready,
  output logic [N_REGIONS*DATA_BITS-1:0]    m_axis_tdata,
  output logic [N_REGIONS*DATA_BITS/8-1:0]  m_axis_tkeep,
  output logic [N_REGIONS-1:0]              m_axis_tlast,

  output logic                              err
);

  localparam int unsigned KeepBits = DATA_BITS / 8;
  localparam logic [N_REGIONS_BITS:0] NRegions = (N_REGIONS_BITS + 1)'(N_REGIONS);

  typedef enum logic {StIdle, StXfer} state_e;

  state_e                    state_q, state_d;
  logic [N_REGIONS_BITS-1:0] vfid_q, vfid_d;
  logic [BLEN_BITS-1:0]      len_q, len_d;
  logic                      last_q, last_d;
  logic [BLEN_BITS-1:0]      cnt_q, cnt_d;

  logic in_range;
  logic final_beat;
  logic beat;

  assign in_range   = {1'b0, vfid_q} < NRegions;
  assign final_beat = (cnt_q == len_q);
  assign beat       = (state_q == StXfer) && s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d       = state_q;
    vfid_d        = vfid_q;
    len_d         = len_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    s_mux_ready   = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = '0;
    m_axis_tlast  = '0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    unique case (state_q)
      StIdle: begin
        // Held low while reset is asserted so upstream never sees a phantom accept.
        s_mux_ready = aresetn;
        if (s_mux_valid) begin
          vfid_d  = s_mux_vfid;
          len_d   = s_mux_len;
          last_d  = s_mux_last;
          cnt_d   = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (in_range) begin
          m_axis_tvalid[vfid_q] = s_axis_tvalid;
          m_axis_tlast[vfid_q]  = final_beat & last_q;
          s_axis_tready         = m_axis_tready[vfid_q];
          m_axis_tdata[vfid_q*DATA_BITS +: DATA_BITS] = s_axis_tdata;
          m_axis_tkeep[vfid_q*KeepBits +: KeepBits]   = s_axis_tkeep;
        end else begin
          // Unroutable entry: swallow its beats so the DMA stream keeps moving.
          s_axis_tready = 1'b1;
        end
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (final_beat) begin
            if (s_mux_valid) begin
              s_mux_ready = 1'b1;
              vfid_d      = s_mux_vfid;
              len_d       = s_mux_len;
              last_d      = s_mux_last;
              cnt_d       = '0;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
      vfid_q  <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vfid_q  <= vfid_d;
      len_q   <= len_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MMU_DMUX_ERR_CHECK_EN
  logic err_q;
  logic err_set;

  assign err_set = (s_mux_valid && s_mux_ready && ({1'b0, s_mux_vfid} >= NRegions))
                || (beat && s_axis_tlast && !final_beat)
                || (beat && !s_axis_tlast && final_beat && last_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_mmu_data_demux.sv
// Directed bench for mmu_data_demux: per-cycle vector table plus hand-written corner sequences.
module tb_mmu_data_demux;

  localparam int unsigned NReg  = 3;
  localparam int unsigned NRB   = 2;
  localparam int unsigned DBits = 16;
  localparam int unsigned KBits = 2;
  localparam int unsigned BLen  = 3;
`ifdef MMU_DMUX_ERR_CHECK_EN
  localparam logic ErrEn = 1'b1;
`else
  localparam logic ErrEn = 1'b0;
`endif

  logic                    aclk = 1'b0;
  logic                    aresetn;
  logic                    s_mux_valid;
  logic                    s_mux_ready;
  logic [NRB-1:0]          s_mux_vfid;
  logic [BLen-1:0]         s_mux_len;
  logic                    s_mux_last;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic [DBits-1:0]        s_axis_tdata;
  logic [KBits-1:0]        s_axis_tkeep;
  logic                    s_axis_tlast;
  logic [NReg-1:0]         m_axis_tvalid;
  logic [NReg-1:0]         m_axis_tready;
  logic [NReg*DBits-1:0]   m_axis_tdata;
  logic [NReg*KBits-1:0]   m_axis_tkeep;
  logic [NReg-1:0]         m_axis_tlast;
  logic                    err;

  mmu_data_demux #(
    .N_REGIONS      (NReg),
    .N_REGIONS_BITS (NRB),
    .DATA_BITS      (DBits),
    .BLEN_BITS      (BLen)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_mux_valid   (s_mux_valid),
    .s_mux_ready   (s_mux_ready),
    .s_mux_vfid    (s_mux_vfid),
    .s_mux_len     (s_mux_len),
    .s_mux_last    (s_mux_last),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .err           (err)
  );

  always #5 aclk = ~aclk;

  int nchk = 0;
  int nerr = 0;
  logic exp_err = 1'b0;

  typedef struct {
    logic            mv;
    logic [NRB-1:0]  vfid;
    logic [BLen-1:0] len;
    logic            last;
    logic            tv;
    logic [15:0]     d;
    logic            tl;
    logic [NReg-1:0] mr;
    logic            e_mr;
    logic            e_tr;
    logic [NReg-1:0] e_v;
    logic [NReg-1:0] e_l;
    int              e_sel;  // region carrying data, NReg = none
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic mv, logic [NRB-1:0] vfid, logic [BLen-1:0] len, logic last,
                              logic tv, logic [15:0] d, logic tl, logic [NReg-1:0] mr,
                              logic e_mr, logic e_tr, logic [NReg-1:0] e_v,
                              logic [NReg-1:0] e_l, int e_sel);
    vec_t v;
    v.mv = mv; v.vfid = vfid; v.len = len; v.last = last; v.tv = tv; v.d = d; v.tl = tl;
    v.mr = mr; v.e_mr = e_mr; v.e_tr = e_tr; v.e_v = e_v; v.e_l = e_l; v.e_sel = e_sel;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Checks the data/keep buses: only region sel carries d (keep = d[1:0]); everything else 0.
  task automatic chk_data(input string name, input int sel, input logic [15:0] d);
    logic [NReg*DBits-1:0] ed;
    logic [NReg*KBits-1:0] ek;
    ed = '0;
    ek = '0;
    if (sel < NReg) begin
      ed[sel*DBits +: DBits] = d;
      ek[sel*KBits +: KBits] = d[1:0];
    end
    chk({name, ".tdata"}, 64'(m_axis_tdata), 64'(ed));
    chk({name, ".tkeep"}, 64'(m_axis_tkeep), 64'(ek));
  endtask

  task automatic drive(input logic mv, input logic [NRB-1:0] vfid, input logic [BLen-1:0] len,
                       input logic last, input logic tv, input logic [15:0] d, input logic tl,
                       input logic [NReg-1:0] mr);
    s_mux_valid   = mv;
    s_mux_vfid    = vfid;
    s_mux_len     = len;
    s_mux_last    = last;
    s_axis_tvalid = tv;
    s_axis_tdata  = d;
    s_axis_tkeep  = d[1:0];
    s_axis_tlast  = tl;
    m_axis_tready = mr;
  endtask

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int hs;
    aresetn = 1'b0;
    drive(1'b1, 2'd0, 3'd0, 1'b0, 1'b1, 16'h0, 1'b0, 3'b111);
    repeat (2) @(posedge aclk);
    #2;
    chk("rst.mux_ready", 64'(s_mux_ready), 64'(0));
    chk("rst.s_tready", 64'(s_axis_tready), 64'(0));
    chk("rst.m_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("rst.m_tlast", 64'(m_axis_tlast), 64'(0));
    chk("rst.err", 64'(err), 64'(0));
    chk_data("rst", NReg, 16'h0);
    drive(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b0, 3'b111);
    next_cycle();
    aresetn = 1'b1;

    // Single entry to region 2
    vecs.push_back(mk(1, 2, 3, 1, 0, 16'h0000, 0, 3'b111, 1, 0, 3'b000, 3'b000, NReg));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'hD000, 0, 3'b111, 0, 1, 3'b100, 3'b000, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'hD001, 0, 3'b111, 0, 1, 3'b100, 3'b000, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'hD002, 0, 3'b111, 0, 1, 3'b100, 3'b000, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'hD003, 1, 3'b111, 0, 1, 3'b100, 3'b100, 2));
    // Back-to-back entries (0,len1,last0) then (1,len0,last1)
    vecs.push_back(mk(1, 0, 1, 0, 0, 16'h0000, 0, 3'b111, 1, 0, 3'b000, 3'b000, NReg));
    vecs.push_back(mk(1, 1, 0, 1, 1, 16'hD004, 0, 3'b111, 0, 1, 3'b001, 3'b000, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 16'hD005, 0, 3'b111, 1, 1, 3'b001, 3'b000, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'hD006, 1, 3'b111, 0, 1, 3'b010, 3'b010, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'hD00F, 0, 3'b111, 1, 0, 3'b000, 3'b000, NReg));
    // Region 1 backpressure for 5 cycles mid-entry
    vecs.push_back(mk(1, 1, 3, 1, 0, 16'h0000, 0, 3'b111, 1, 0, 3'b000, 3'b000, NReg));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'hD007, 0, 3'b111, 0, 1, 3'b010, 3'b000, 1));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 0, 0, 0, 1, 16'hD008, 0, 3'b101, 0, 0, 3'b010, 3'b000, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'hD008, 0, 3'b111, 0, 1, 3'b010, 3'b000, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'hD009, 0, 3'b111, 0, 1, 3'b010, 3'b000, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'hD00A, 1, 3'b111, 0, 1, 3'b010, 3'b010, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 3'b111, 1, 0, 3'b000, 3'b000, NReg));

    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      drive(vecs[i].mv, vecs[i].vfid, vecs[i].len, vecs[i].last, vecs[i].tv, vecs[i].d,
            vecs[i].tl, vecs[i].mr);
      #1;
      chk({nm, ".mux_ready"}, 64'(s_mux_ready), 64'(vecs[i].e_mr));
      chk({nm, ".s_tready"}, 64'(s_axis_tready), 64'(vecs[i].e_tr));
      chk({nm, ".m_tvalid"}, 64'(m_axis_tvalid), 64'(vecs[i].e_v));
      chk({nm, ".m_tlast"}, 64'(m_axis_tlast), 64'(vecs[i].e_l));
      chk({nm, ".err"}, 64'(err), 64'(exp_err));
      chk_data(nm, vecs[i].e_sel, vecs[i].d);
      next_cycle();
    end

    // Full-length entry: len=7 -> 8 beats to region 0, then back to idle
    drive(1, 0, 3'd7, 1, 0, 16'h0, 0, 3'b111);
    #1;
    chk("full.accept", 64'(s_mux_ready), 64'(1));
    next_cycle();
    hs = 0;
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 0, 1, 16'hE000 + 16'(k), k == 7, 3'b111);
      #1;
      chk($sformatf("full.b%0d.tvalid", k), 64'(m_axis_tvalid), 64'(3'b001));
      chk($sformatf("full.b%0d.tlast", k), 64'(m_axis_tlast), 64'((k == 7) ? 3'b001 : 3'b000));
      chk_data($sformatf("full.b%0d", k), 0, 16'hE000 + 16'(k));
      if (m_axis_tvalid[0] && m_axis_tready[0] && s_axis_tready) hs++;
      next_cycle();
    end
    chk("full.beats", 64'(hs), 64'(8));
    drive(0, 0, 0, 0, 1, 16'h0, 0, 3'b111);
    #1;
    chk("full.idle.mux_ready", 64'(s_mux_ready), 64'(1));
    chk("full.idle.s_tready", 64'(s_axis_tready), 64'(0));
    chk("full.idle.m_tvalid", 64'(m_axis_tvalid), 64'(0));
    next_cycle();

    // tlast on beat 1 of a len=3 entry: flagged when checking is built in, routing unchanged
    drive(1, 0, 3'd3, 1, 0, 16'h0, 0, 3'b111);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 1, 16'hF000 + 16'(k), (k == 1) || (k == 3), 3'b111);
      #1;
      chk($sformatf("tl.b%0d.tvalid", k), 64'(m_axis_tvalid), 64'(3'b001));
      chk($sformatf("tl.b%0d.tlast", k), 64'(m_axis_tlast), 64'((k == 3) ? 3'b001 : 3'b000));
      chk($sformatf("tl.b%0d.err", k), 64'(err), 64'(exp_err));
      if (k == 1) exp_err = ErrEn;
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 16'h0, 0, 3'b111);
    #1;
    chk("tl.after.err", 64'(err), 64'(exp_err));
    next_cycle();

    // Out-of-range vfid=3: beats swallowed, nothing routed
    drive(1, 3, 3'd1, 0, 0, 16'h0, 0, 3'b111);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 1, 16'hB000 + 16'(k), 0, 3'b000);
      #1;
      chk($sformatf("oor.b%0d.s_tready", k), 64'(s_axis_tready), 64'(1));
      chk($sformatf("oor.b%0d.m_tvalid", k), 64'(m_axis_tvalid), 64'(0));
      chk_data($sformatf("oor.b%0d", k), NReg, 16'h0);
      next_cycle();
    end
    exp_err = ErrEn;
    drive(0, 0, 0, 0, 0, 16'h0, 0, 3'b111);
    #1;
    chk("oor.idle.mux_ready", 64'(s_mux_ready), 64'(1));
    chk("oor.err", 64'(err), 64'(exp_err));
    next_cycle();

    // Reset during beat 2 of a len=7 entry to region 2
    drive(1, 2, 3'd7, 1, 0, 16'h0, 0, 3'b111);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 1, 16'hC000 + 16'(k), 0, 3'b111);
      #1;
      chk($sformatf("mid.b%0d.tvalid", k), 64'(m_axis_tvalid), 64'(3'b100));
      if (k < 2) next_cycle();
    end
    aresetn = 1'b0;
    exp_err = 1'b0;
    #1;
    chk("mid.rst.m_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("mid.rst.m_tlast", 64'(m_axis_tlast), 64'(0));
    chk("mid.rst.s_tready", 64'(s_axis_tready), 64'(0));
    chk("mid.rst.mux_ready", 64'(s_mux_ready), 64'(0));
    chk("mid.rst.err", 64'(err), 64'(0));
    chk_data("mid.rst", NReg, 16'h0);
    next_cycle();
    aresetn = 1'b1;
    drive(1, 0, 3'd0, 1, 0, 16'h0, 0, 3'b111);
    #1;
    chk("post.accept", 64'(s_mux_ready), 64'(1));
    next_cycle();
    drive(0, 0, 0, 0, 1, 16'hA5A6, 1, 3'b111);
    #1;
    chk("post.tvalid", 64'(m_axis_tvalid), 64'(3'b001));
    chk("post.tlast", 64'(m_axis_tlast), 64'(3'b001));
    chk("post.s_tready", 64'(s_axis_tready), 64'(1));
    chk_data("post", 0, 16'hA5A6);
    next_cycle();
    drive(0, 0, 0, 0, 0, 16'h0, 0, 3'b111);
    #1;
    chk("post.idle.mux_ready", 64'(s_mux_ready), 64'(1));
    chk("post.idle.m_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("post.err", 64'(err), 64'(exp_err));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
